io_port_responder: RTL and testbench
====================================

// Module: io_port_responder
// PURPOSE
//  Device side of the TinyComp I/O port. Two FIFOs: input FIFO feeds InData/InRdy, popped by InStrobe.
//  Output FIFO captures OutData on OutStrobe and drains to an external valid/ready sink.
//  One Ph0 cycle is one instruction. Sits beside the CPU. External producer/consumer attach via valid/ready.
// PARAMETERS
//  WIDTH       32  data word width, in and out
//  DEPTH_LOG2  4   log2 of the entry count of each FIFO (16 entries)
// PORTS
//  Ph0          in   1      clock; single clock domain; all state updates on posedge Ph0
//  Reset        in   1      synchronous, active-high reset
//  InStrobe     in   1      CPU executing Input instruction this cycle
//  InData       out  WIDTH  head of input FIFO; 0 when empty
//  InRdy        out  1      input FIFO not empty
//  OutStrobe    in   1      CPU executing Output instruction this cycle
//  OutData      in   WIDTH  CPU output word (register-file port A), valid while OutStrobe=1
//  ExtInData    in   WIDTH  external producer word
//  ExtInValid   in   1      producer offers ExtInData
//  ExtInReady   out  1      input FIFO accepts (= not full)
//  ExtOutData   out  WIDTH  head of output FIFO; 0 when empty
//  ExtOutValid  out  1      output FIFO not empty
//  ExtOutReady  in   1      consumer accepts ExtOutData
//  Underflow    out  1      sticky: InStrobe seen while input FIFO empty
//  Overflow     out  1      sticky: OutStrobe seen while output FIFO full
// BEHAVIOUR
//  Reset (sync, Ph0 edge): pointers/counts=0, both FIFOs empty; InRdy=0, ExtOutValid=0, ExtInReady=1,
//   InData=0, ExtOutData=0, Underflow=0, Overflow=0. Reset mid-transfer discards all stored words.
//  FIFO storage: registered array, combinational read at read pointer. Pointers DEPTH_LOG2 bits, wrap mod
//   2**DEPTH_LOG2. Count DEPTH_LOG2+1 bits, 0..2**DEPTH_LOG2.
//  Input FIFO:
//   - push when ExtInValid & ExtInReady.
//   - pop when InStrobe & InRdy.
//   - InData must be stable within the cycle InStrobe is high; the CPU writes it at the same Ph0 edge as the pop.
//   - Latency: word pushed at edge N is visible on InData/InRdy after edge N (usable by next instruction).
//  Output FIFO:
//   - push OutData when OutStrobe & not full.
//   - pop when ExtOutValid & ExtOutReady.
//  Strobes last exactly one Ph0 cycle per instruction; each high cycle is one push/pop, never more.
//  Boundaries:
//   - full: ExtInReady=0 even if InStrobe pops same cycle (no bypass); output-FIFO full + OutStrobe -> word dropped, Overflow<=1.
//   - empty: InStrobe -> no pop, InData=0, Underflow<=1; CPU polls InRdy via skip to avoid this.
//   - simultaneous push+pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
//   - push into empty FIFO with pop attempt same cycle: push taken, pop ignored, Underflow<=1.
//  Underflow/Overflow clear only on Reset.
// CONFIGURATION
//  IO_LOOPBACK_EN defined: extra input port Loopback (1 bit).
//   - Loopback=1: output-FIFO head pushes into input FIFO when both sides allow, one word per cycle.
//   - Loopback=1: ExtOutValid=0 and ExtInReady=0.
//   - Loopback=0: normal behaviour.
//  IO_LOOPBACK_EN undefined: no Loopback port, no loopback path; behaviour identical to Loopback=0.
// STRUCTURE
//  Shared package io_port_pkg: IO_WIDTH=32, IO_DEPTH_LOG2=4 defaults; typedef io_word_t (logic [IO_WIDTH-1:0]).
//  One sub-module io_sync_fifo (WIDTH, DEPTH_LOG2):
//   - ports: push, push_data, pop, head, empty, full.
//   - push/pop gated internally by full/empty.
//   - instantiated twice.
//  Top module holds handshake gating, sticky flags and the loopback mux.
// TESTING
//  1. Reset held 2 cycles -> InRdy=0, ExtInReady=1, ExtOutValid=0, Underflow=Overflow=0, InData=0.
//  2. Ext push 0x0000_00A5 then 0x1234_5678; InStrobe 2 cycles -> InData A5 then 12345678, InRdy 0 after.
//  3. 16 ext pushes -> ExtInReady=0 on 17th; pop+offer same cycle -> offer refused, count=15 next cycle.
//  4. OutStrobe x17 with ExtOutReady=0, data 0..16 -> 16 stored, Overflow=1; drain yields 0..15 in order.
//  5. InStrobe on empty FIFO -> InData=0, no pointer change, Underflow=1 and stays 1 until Reset.
//  6. (IO_LOOPBACK_EN) Loopback=1, OutStrobe 0xDEAD_BEEF -> InRdy=1 within 2 cycles, InData=DEADBEEF, ExtOutValid=0.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared definitions for the TinyComp I/O port responder.
// Optional build macro: IO_LOOPBACK_EN (adds the Loopback input to io_port_responder).
package io_port_pkg;
  localparam int IO_WIDTH      = 32;
  localparam int IO_DEPTH_LOG2 = 4;

  typedef logic [IO_WIDTH-1:0] io_word_t;
endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with registered storage and combinational head read.
// Push is ignored when full, pop is ignored when empty; head reads 0 when empty.
module io_sync_fifo
  import io_port_pkg::*;
#(
  parameter int WIDTH      = IO_WIDTH,
  parameter int DEPTH_LOG2 = IO_DEPTH_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Occupancy: push+pop together leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Pointer/count state; storage words are discarded by resetting pointers only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage write; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/io_port_responder.sv
// Device side of the TinyComp I/O port: input FIFO (external producer -> CPU)
// and output FIFO (CPU -> external consumer), with sticky under/overflow flags.
// Optional build macro: IO_LOOPBACK_EN adds a Loopback input that routes the
// output FIFO head into the input FIFO and blocks the external handshakes.
module io_port_responder
  import io_port_pkg::*;
#(
  parameter int WIDTH      = IO_WIDTH,
  parameter int DEPTH_LOG2 = IO_DEPTH_LOG2
) (
  input  logic             Ph0,
  input  logic             Reset,
  input  logic             InStrobe,
  output logic [WIDTH-1:0] InData,
  output logic             InRdy,
  input  logic             OutStrobe,
  input  logic [WIDTH-1:0] OutData,
  input  logic [WIDTH-1:0] ExtInData,
  input  logic             ExtInValid,
  output logic             ExtInReady,
  output logic [WIDTH-1:0] ExtOutData,
  output logic             ExtOutValid,
  input  logic             ExtOutReady,
`ifdef IO_LOOPBACK_EN
  input  logic             Loopback,
`endif
  output logic             Underflow,
  output logic             Overflow
);
  logic             lb, lb_move;
  logic             in_push, in_empty, in_full;
  logic [WIDTH-1:0] in_push_data, in_head;
  logic             out_pop, out_empty, out_full;
  logic [WIDTH-1:0] out_head;
  logic             underflow_q, underflow_d, overflow_q, overflow_d;

`ifdef IO_LOOPBACK_EN
  assign lb = Loopback;
`else
  assign lb = 1'b0;
`endif

  // One word per cycle moves from output head to input FIFO when both allow.
  assign lb_move = lb & ~out_empty & ~in_full;

  // Input side: full blocks the producer even if the CPU pops this cycle.
  assign ExtInReady   = ~in_full & ~lb;
  assign in_push      = lb ? lb_move : (ExtInValid & ExtInReady);
  assign in_push_data = lb ? out_head : ExtInData;
  assign InRdy        = ~in_empty;
  assign InData       = in_head;

  // Output side: consumer sees nothing while looping back.
  assign ExtOutValid = ~out_empty & ~lb;
  assign ExtOutData  = out_head;
  assign out_pop     = lb ? lb_move : (ExtOutValid & ExtOutReady);

  io_sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_in_fifo (
    .clk(Ph0), .rst(Reset),
    .push(in_push), .push_data(in_push_data), .pop(InStrobe),
    .head(in_head), .empty(in_empty), .full(in_full)
  );

  io_sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_out_fifo (
    .clk(Ph0), .rst(Reset),
    .push(OutStrobe), .push_data(OutData), .pop(out_pop),
    .head(out_head), .empty(out_empty), .full(out_full)
  );

  // Sticky error flags: set on a strobe the FIFO cannot honour.
  always_comb begin
    underflow_d = underflow_q | (InStrobe & in_empty);
    overflow_d  = overflow_q | (OutStrobe & out_full);
  end

  // Flag registers, cleared only by Reset.
  always_ff @(posedge Ph0) begin
    if (Reset) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  assign Underflow = underflow_q;
  assign Overflow  = overflow_q;
endmodule

// File: tb/tb_io_port_responder.sv
// Directed self-checking bench for io_port_responder.
module tb_io_port_responder;
  import io_port_pkg::*;

  logic     Ph0 = 1'b0;
  logic     Reset, InStrobe, InRdy, OutStrobe, ExtInValid, ExtInReady;
  logic     ExtOutValid, ExtOutReady, Underflow, Overflow;
  io_word_t InData, OutData, ExtInData, ExtOutData;
`ifdef IO_LOOPBACK_EN
  logic     Loopback;
`endif

  int compared   = 0;
  int mismatched = 0;

  io_port_responder dut (
    .Ph0(Ph0), .Reset(Reset),
    .InStrobe(InStrobe), .InData(InData), .InRdy(InRdy),
    .OutStrobe(OutStrobe), .OutData(OutData),
    .ExtInData(ExtInData), .ExtInValid(ExtInValid), .ExtInReady(ExtInReady),
    .ExtOutData(ExtOutData), .ExtOutValid(ExtOutValid), .ExtOutReady(ExtOutReady),
`ifdef IO_LOOPBACK_EN
    .Loopback(Loopback),
`endif
    .Underflow(Underflow), .Overflow(Overflow)
  );

  always #5 Ph0 = ~Ph0;

  // Advance one Ph0 edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge Ph0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; InStrobe = 1'b0; OutStrobe = 1'b0; OutData = '0;
    ExtInData = '0; ExtInValid = 1'b0; ExtOutReady = 1'b0;
`ifdef IO_LOOPBACK_EN
    Loopback = 1'b0;
`endif
    // 1. reset
    tick(); tick();
    Reset = 1'b0;
    chk("rst_InRdy", 32'(InRdy), 0);
    chk("rst_ExtInReady", 32'(ExtInReady), 1);
    chk("rst_ExtOutValid", 32'(ExtOutValid), 0);
    chk("rst_Underflow", 32'(Underflow), 0);
    chk("rst_Overflow", 32'(Overflow), 0);
    chk("rst_InData", InData, 0);
    chk("rst_ExtOutData", ExtOutData, 0);

    // 2. two external pushes, two CPU pops
    ExtInValid = 1'b1; ExtInData = 32'h0000_00A5;
    tick();
    chk("t2_InRdy_after_push", 32'(InRdy), 1);
    chk("t2_InData_first", InData, 32'h0000_00A5);
    ExtInData = 32'h1234_5678;
    tick();
    ExtInValid = 1'b0;
    InStrobe = 1'b1;
    chk("t2_InData_pop1", InData, 32'h0000_00A5);
    tick();
    chk("t2_InData_pop2", InData, 32'h1234_5678);
    tick();
    InStrobe = 1'b0;
    chk("t2_InRdy_empty", 32'(InRdy), 0);
    chk("t2_InData_empty", InData, 0);
    chk("t2_Underflow", 32'(Underflow), 0);

    // 3. fill input FIFO, then pop while offering
    ExtInValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ExtInData = 32'(100 + i);
      tick();
    end
    ExtInData = 32'h0000_0BAD;
    chk("t3_full_ExtInReady", 32'(ExtInReady), 0);
    InStrobe = 1'b1;
    chk("t3_full_pop_ExtInReady", 32'(ExtInReady), 0);
    chk("t3_head", InData, 100);
    tick();
    InStrobe = 1'b0; ExtInValid = 1'b0;
    chk("t3_after_pop_ExtInReady", 32'(ExtInReady), 1);
    InStrobe = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("t3_drain%0d", i), InData, 32'(101 + i));
      tick();
    end
    InStrobe = 1'b0;
    chk("t3_drained_InRdy", 32'(InRdy), 0);
    chk("t3_Underflow", 32'(Underflow), 0);

    // 4. overflow the output FIFO, then drain in order
    ExtOutReady = 1'b0; OutStrobe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      OutData = 32'(i);
      tick();
    end
    chk("t4_no_ovf_at16", 32'(Overflow), 0);
    OutData = 32'd16;
    tick();
    OutStrobe = 1'b0;
    chk("t4_Overflow", 32'(Overflow), 1);
    ExtOutReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t4_valid%0d", i), 32'(ExtOutValid), 1);
      chk($sformatf("t4_data%0d", i), ExtOutData, 32'(i));
      tick();
    end
    ExtOutReady = 1'b0;
    chk("t4_empty_valid", 32'(ExtOutValid), 0);
    chk("t4_empty_data", ExtOutData, 0);
    chk("t4_Overflow_sticky", 32'(Overflow), 1);

    // 5. underflow, sticky; push+pop on empty; push+pop on non-empty
    InStrobe = 1'b1;
    tick();
    InStrobe = 1'b0;
    chk("t5_Underflow", 32'(Underflow), 1);
    chk("t5_InData", InData, 0);
    chk("t5_InRdy", 32'(InRdy), 0);
    ExtInValid = 1'b1; ExtInData = 32'h0000_0055; InStrobe = 1'b1;
    tick();
    ExtInValid = 1'b0; InStrobe = 1'b0;
    chk("t5_push_on_empty_kept", InData, 32'h0000_0055);
    ExtInValid = 1'b1; ExtInData = 32'h0000_0066; InStrobe = 1'b1;
    tick();
    ExtInValid = 1'b0; InStrobe = 1'b0;
    chk("t5_pushpop_head", InData, 32'h0000_0066);
    InStrobe = 1'b1;
    tick();
    InStrobe = 1'b0;
    chk("t5_pushpop_count1", 32'(InRdy), 0);
    chk("t5_Underflow_sticky", 32'(Underflow), 1);

    // reset mid-transfer discards stored words and clears flags
    ExtInValid = 1'b1; ExtInData = 32'h0000_0077; OutStrobe = 1'b1; OutData = 32'h0000_0088;
    tick();
    ExtInValid = 1'b0; OutStrobe = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst2_InRdy", 32'(InRdy), 0);
    chk("rst2_ExtOutValid", 32'(ExtOutValid), 0);
    chk("rst2_Underflow", 32'(Underflow), 0);
    chk("rst2_Overflow", 32'(Overflow), 0);

`ifdef IO_LOOPBACK_EN
    // 6. loopback path
    Loopback = 1'b1; OutStrobe = 1'b1; OutData = 32'hDEAD_BEEF; ExtOutReady = 1'b1;
    tick();
    OutStrobe = 1'b0;
    chk("t6_ExtOutValid", 32'(ExtOutValid), 0);
    chk("t6_ExtInReady", 32'(ExtInReady), 0);
    tick();
    chk("t6_InRdy", 32'(InRdy), 1);
    chk("t6_InData", InData, 32'hDEAD_BEEF);
    chk("t6_ExtOutValid_after", 32'(ExtOutValid), 0);
    Loopback = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
